// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer
// Brief   : Fetch/decode/execute/writeback controller for a 4x4-bit register file.
// Revision: 1.0
// ============================================================================
module instr_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [PC_W-1:0]   pc,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    input  logic [7:0]        read_data1,
    input  logic [7:0]        read_data2,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              halted,
    output logic [7:0]        retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t              state_q, state_d;
    logic [7:0]          instr_q, instr_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          retired_q, retired_d;
    logic [ADDR_W-1:0]   read_addr1_q, read_addr1_d;
    logic [ADDR_W-1:0]   read_addr2_q, read_addr2_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [DATA_W-1:0]   alu_result;

    // Upper read-data bits belong to the wider register file bus and are ignored.
    logic unused_read_hi;
    assign unused_read_hi = ^{read_data1[7:DATA_W], read_data2[7:DATA_W]};

    always_comb begin
        alu_result = '0;
        case (instr_q[7:6])
            OP_ADD:  alu_result = op_a_q + op_b_q;
            OP_SUB:  alu_result = op_a_q - op_b_q;
            OP_LI:   alu_result = DATA_W'(instr_q[3:0]);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        pc_d         = pc_q;
        retired_d    = retired_q;
        read_addr1_d = read_addr1_q;
        read_addr2_d = read_addr2_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    if (instr[7:6] == OP_HALT) begin
                        state_d = S_HALTED;
                    end else begin
                        // Addresses are registered at accept so they are stable for all of DECODE.
                        read_addr1_d = instr[3:2];
                        read_addr2_d = instr[1:0];
                        state_d      = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                op_a_d  = read_data1[DATA_W-1:0];
                op_b_d  = read_data2[DATA_W-1:0];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                write_data_d = alu_result;
                write_addr_d = instr_q[5:4];
                state_d      = S_WB;
            end
            S_WB: begin
                pc_d = pc_q + 1'b1;
                if (retired_q != 8'hFF) begin
                    retired_d = retired_q + 8'd1;
                end
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            instr_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            pc_q         <= '0;
            retired_q    <= '0;
            read_addr1_q <= '0;
            read_addr2_q <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            pc_q         <= pc_d;
            retired_q    <= retired_d;
            read_addr1_q <= read_addr1_d;
            read_addr2_q <= read_addr2_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign instr_ready  = (state_q == S_FETCH);
    assign write_enable = (state_q == S_WB);
    assign halted       = (state_q == S_HALTED);
    assign pc           = pc_q;
    assign retired      = retired_q;
    assign read_addr1   = read_addr1_q;
    assign read_addr2   = read_addr2_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_sequencer
// Brief   : Scoreboard bench for instr_sequencer with a behavioural register file.
// Revision: 1.0
// ============================================================================
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic [1:0] read_addr1;
    logic [1:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic [1:0] write_addr;
    logic [3:0] write_data;
    logic       write_enable;
    logic       halted;
    logic [7:0] retired;

    int checks;
    int passes;
    logic [5:0] exp_q[$];
    logic [3:0] rf[4];

    instr_sequencer #(.DATA_W(4), .ADDR_W(2), .PC_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc           (pc),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; upper bus bits are junk the sequencer must mask off.
    always @(posedge clk) begin
        if (write_enable) rf[write_addr] <= write_data;
    end
    assign read_data1 = {4'hA, rf[read_addr1]};
    assign read_data2 = {4'h5, rf[read_addr2]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected writeback.
    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {26'd0, write_addr, write_data}, 32'hFFFF);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("wb_addr_data", {26'd0, write_addr, write_data}, {26'd0, e});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addrs", {read_addr1, read_addr2, write_addr}, 0);
        chk("rst_wdata", write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for ready at a negedge, presents the instruction, returns #1 after the accept edge.
    task automatic send(input logic [7:0] ins, input bit push, input logic [5:0] exp,
                        output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!instr_ready && waited < 50);
        if (!instr_ready) chk("send_timeout", 0, 1);
        if (push) exp_q.push_back(exp);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 50);
        if (!instr_ready) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int w;
        bit all_ready;
        checks = 0;
        passes = 0;
        rst_n = 1'b1;
        instr = 8'h00;
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) rf[i] = 4'd0;
        #2 rst_n = 1'b0;
        #10;
        do_reset();

        // LI r1,5; LI r2,3; ADD r3,r1,r2
        send(8'h95, 1, {2'd1, 4'd5}, w);
        send(8'hA3, 1, {2'd2, 4'd3}, w);
        send(8'h36, 1, {2'd3, 4'd8}, w);
        wait_done();
        chk("t1_pc", pc, 3);
        chk("t1_retired", retired, 3);

        // Idle for 20 cycles, then first-edge acceptance
        all_ready = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!instr_ready || write_enable) all_ready = 0;
        end
        chk("idle_ready_no_we", all_ready, 1);
        chk("idle_pc", pc, 3);
        send(8'h93, 1, {2'd1, 4'd3}, w);
        chk("idle_first_edge", w, 1);
        chk("busy_not_ready", instr_ready, 0);

        // SUB wrap and ADD wrap
        send(8'hA5, 1, {2'd2, 4'd5}, w);
        send(8'h76, 1, {2'd3, 4'd14}, w);
        send(8'h89, 1, {2'd0, 4'd9}, w);
        send(8'h20, 1, {2'd2, 4'd2}, w);
        wait_done();
        chk("t2_pc", pc, 8);
        chk("t2_retired", retired, 8);

        // HALT after two LIs
        do_reset();
        send(8'h91, 1, {2'd1, 4'd1}, w);
        send(8'hA2, 1, {2'd2, 4'd2}, w);
        send(8'hC0, 0, 6'd0, w);
        chk("halt_halted", halted, 1);
        chk("halt_ready", instr_ready, 0);
        chk("halt_pc", pc, 2);
        chk("halt_retired", retired, 2);
        instr = 8'h93;
        instr_valid = 1'b1;
        repeat (10) @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_hold_pc", pc, 2);
        chk("halt_hold_retired", retired, 2);
        chk("halt_hold_halted", halted, 1);

        // Reset during EXEC drops the write
        do_reset();
        send(8'hA7, 0, 6'd0, w);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_we", write_enable, 0);
        chk("exec_rst_pc", pc, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("exec_rst_retired", retired, 0);
        send(8'hB2, 1, {2'd3, 4'd2}, w);
        wait_done();
        chk("post_rst_pc", pc, 1);
        chk("post_rst_retired", retired, 1);

        // Reset while write strobe is high: strobe drops asynchronously
        send(8'h99, 0, 6'd0, w);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wb_we_high", write_enable, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("wb_rst_we_async", write_enable, 0);
        chk("wb_rst_pc", pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 256 LIs: pc wraps, retired saturates
        do_reset();
        for (int k = 0; k < 256; k++) begin
            logic [3:0] v;
            v = k[3:0];
            send({4'b1000, v}, 1, {2'd0, v}, w);
            if (k == 254) begin
                wait_done();
                chk("wrap_pc_255", pc, 255);
                chk("wrap_ret_255", retired, 255);
            end
        end
        wait_done();
        chk("wrap_pc_0", pc, 0);
        chk("wrap_ret_sat", retired, 255);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
